// File: rtl/ro_sensor_scheduler.sv
// Ring-oscillator sensor scheduler: walks the requested sensors one at a time through
// counter clear, oscillator run window, settle and capture, then presents each count
// on a valid/ready result port.
module ro_sensor_scheduler #(
    parameter int NUM_SENSORS   = 4,
    parameter int CLEAR_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [NUM_SENSORS-1:0]     sensor_mask,
    input  logic [31:0]                window_cycles,
    input  logic [64*NUM_SENSORS-1:0]  cnt_val,
    output logic [NUM_SENSORS-1:0]     sensor_en,
    output logic                       cnt_reset,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [63:0]                result_data,
    output logic [7:0]                 result_id,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StSettle,
        StCapture,
        StOutput
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             phase_q, phase_d;
    logic [31:0]             window_q, window_d;
    logic [NUM_SENSORS-1:0]  mask_q, mask_d;
    logic [7:0]              sel_q, sel_d;
    logic [7:0]              first_idx, next_idx;
    logic                    has_next;
    logic                    done_d;
    logic [NUM_SENSORS-1:0]  en_d;
    logic [63:0]             cap_data;

    // Sensor selection: lowest requested bit, next latched bit above sel, and sel's count.
    always_comb begin
        first_idx = '0;
        next_idx  = '0;
        has_next  = 1'b0;
        cap_data  = '0;
        // Descending scan so the lowest qualifying index wins.
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            if (sensor_mask[i]) begin
                first_idx = 8'(i);
            end
            if (mask_q[i] && (8'(i) > sel_q)) begin
                next_idx = 8'(i);
                has_next = 1'b1;
            end
            if (sel_q == 8'(i)) begin
                cap_data = cnt_val[64*i +: 64];
            end
        end
    end

    // Next-state, phase countdown and next output enables.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        window_d = window_q;
        mask_d   = mask_q;
        sel_d    = sel_q;
        done_d   = 1'b0;
        en_d     = '0;
        unique case (state_q)
            StIdle: begin
                if (start && (sensor_mask != '0)) begin
                    mask_d   = sensor_mask;
                    // A zero-length window still runs the oscillator for one cycle.
                    window_d = (window_cycles == 32'd0) ? 32'd1 : window_cycles;
                    sel_d    = first_idx;
                    phase_d  = 32'(CLEAR_CYCLES - 1);
                    state_d  = StClear;
                end
            end
            StClear: begin
                if (phase_q == 32'd0) begin
                    phase_d = window_q - 32'd1;
                    state_d = StRun;
                end else begin
                    phase_d = phase_q - 32'd1;
                end
            end
            StRun: begin
                if (phase_q == 32'd0) begin
                    phase_d = 32'(SETTLE_CYCLES - 1);
                    state_d = StSettle;
                end else begin
                    phase_d = phase_q - 32'd1;
                end
            end
            StSettle: begin
                if (phase_q == 32'd0) begin
                    state_d = StCapture;
                end else begin
                    phase_d = phase_q - 32'd1;
                end
            end
            StCapture: begin
                state_d = StOutput;
            end
            StOutput: begin
                if (result_ready) begin
                    if (has_next) begin
                        sel_d   = next_idx;
                        phase_d = 32'(CLEAR_CYCLES - 1);
                        state_d = StClear;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Abort overrides every transition, including a completing handshake.
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            done_d  = 1'b0;
        end
        for (int i = 0; i < NUM_SENSORS; i++) begin
            en_d[i] = (state_d == StRun) && (sel_d == 8'(i));
        end
    end

    // State, latched sweep parameters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            phase_q      <= '0;
            window_q     <= '0;
            mask_q       <= '0;
            sel_q        <= '0;
            sensor_en    <= '0;
            cnt_reset    <= 1'b1;
            result_valid <= 1'b0;
            result_data  <= '0;
            result_id    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            window_q     <= window_d;
            mask_q       <= mask_d;
            sel_q        <= sel_d;
            sensor_en    <= en_d;
            cnt_reset    <= (state_d == StIdle) || (state_d == StClear);
            result_valid <= (state_d == StOutput);
            busy         <= (state_d != StIdle);
            done         <= done_d;
            // Oscillator is stopped and settled here, so cnt_val is sampled directly.
            if ((state_q == StCapture) && (state_d == StOutput)) begin
                result_data <= cap_data;
                result_id   <= sel_q;
            end
        end
    end

endmodule

// File: tb/tb_ro_sensor_scheduler.sv
// Bench for ro_sensor_scheduler: counter plant, timeline reference model, per-cycle compare,
// directed scenarios with literal expectations and randomized sweeps.
module tb_ro_sensor_scheduler;

    localparam int N = 4;
    localparam int C = 4;
    localparam int S = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               result_ready = 1'b0;
    logic [N-1:0]       sensor_mask = '0;
    logic [31:0]        window_cycles = '0;
    logic [64*N-1:0]    cnt_val;
    logic [N-1:0]       sensor_en;
    logic               cnt_reset;
    logic               result_valid;
    logic [63:0]        result_data;
    logic [7:0]         result_id;
    logic               busy;
    logic               done;

    int tests  = 0;
    int failed = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ro_sensor_scheduler #(
        .NUM_SENSORS   (N),
        .CLEAR_CYCLES  (C),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .sensor_mask   (sensor_mask),
        .window_cycles (window_cycles),
        .cnt_val       (cnt_val),
        .sensor_en     (sensor_en),
        .cnt_reset     (cnt_reset),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_data   (result_data),
        .result_id     (result_id),
        .busy          (busy),
        .done          (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Counter plant: sensor i advances by step[i] per clock while enabled.
    logic [63:0] ctr [N];
    int          step [N];
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (cnt_reset) ctr[i] <= '0;
            else if (sensor_en[i]) ctr[i] <= ctr[i] + 64'(step[i]);
        end
    end
    always_comb begin
        cnt_val = '0;
        for (int i = 0; i < N; i++) cnt_val[64*i +: 64] = ctr[i];
    end

    // Observation log for the directed literal checks.
    int          en_cnt [N];
    int          done_cnt;
    int          log_id [$];
    logic [63:0] log_data [$];
    always @(posedge clk) begin
        if (chk_en && !reset) begin
            for (int i = 0; i < N; i++) if (sensor_en[i]) en_cnt[i]++;
            if (done) done_cnt++;
            if (result_valid && result_ready) begin
                log_id.push_back(int'(result_id));
                log_data.push_back(result_data);
            end
        end
    end

    // Reference model: a sweep is a sequence of per-sensor segments; m_t counts cycles since
    // the segment began (clear, then window run, then settle, one capture, then output).
    bit          m_act;
    int          m_t, m_sel, m_win;
    logic [N-1:0] m_mask;
    logic [63:0] m_data;
    logic [7:0]  m_id;
    bit          m_done;

    function automatic int lowest_above(input logic [N-1:0] mk, input int from);
        for (int i = 0; i < N; i++) if (mk[i] && i > from) return i;
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act = 0; m_t = 0; m_sel = 0; m_win = 0; m_mask = '0;
            m_data = '0; m_id = '0; m_done = 0;
        end else begin
            m_done = 0;
            if (!m_act) begin
                if (start && sensor_mask != '0) begin
                    m_act  = 1;
                    m_mask = sensor_mask;
                    m_win  = (window_cycles == 0) ? 1 : int'(window_cycles);
                    m_sel  = lowest_above(sensor_mask, -1);
                    m_t    = 0;
                end
            end else if (abort) begin
                m_act = 0;
            end else if (m_t >= C + m_win + S + 1) begin
                if (result_ready) begin
                    int nxt;
                    nxt = lowest_above(m_mask, m_sel);
                    if (nxt >= 0) begin
                        m_sel = nxt;
                        m_t   = 0;
                    end else begin
                        m_act  = 0;
                        m_done = 1;
                    end
                end
            end else begin
                if (m_t == C + m_win + S) begin
                    m_data = 64'(m_win) * 64'(step[m_sel]);
                    m_id   = 8'(m_sel);
                end
                m_t++;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] e_en;
            e_en = '0;
            if (m_act && m_t >= C && m_t < C + m_win) e_en[m_sel] = 1'b1;
            check("sensor_en", 64'(sensor_en), 64'(e_en));
            check("cnt_reset", 64'(cnt_reset), 64'(!m_act || m_t < C));
            check("result_valid", 64'(result_valid), 64'(m_act && m_t >= C + m_win + S + 1));
            check("busy", 64'(busy), 64'(m_act));
            check("done", 64'(done), 64'(m_done));
            check("result_data", result_data, m_data);
            check("result_id", 64'(result_id), 64'(m_id));
        end
    end

    task automatic clear_logs();
        for (int i = 0; i < N; i++) en_cnt[i] = 0;
        done_cnt = 0;
        log_id.delete();
        log_data.delete();
    endtask

    task automatic begin_sweep(input logic [N-1:0] mk, input logic [31:0] win);
        @(negedge clk);
        start = 1'b1; sensor_mask = mk; window_cycles = win;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin @(negedge clk); n++; end
        check("wait_idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic wait_en(input int idx, input int max);
        int n = 0;
        while (!sensor_en[idx] && n < max) begin @(negedge clk); n++; end
        check("wait_en_timeout", 64'(sensor_en[idx]), 64'(1));
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!result_valid && n < max) begin @(negedge clk); n++; end
        check("wait_valid_timeout", 64'(result_valid), 64'(1));
    endtask

    initial begin
        for (int i = 0; i < N; i++) step[i] = 1;
        clear_logs();
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sensor_en", 64'(sensor_en), 64'(0));
        check("rst_cnt_reset", 64'(cnt_reset), 64'(1));
        check("rst_valid", 64'(result_valid), 64'(0));
        check("rst_data", result_data, 64'(0));
        check("rst_id", 64'(result_id), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        reset  = 1'b0;
        chk_en = 1'b1;

        // Two sensors, window 100, ready always high.
        clear_logs();
        result_ready = 1'b1;
        begin_sweep(4'b0101, 32'd100);
        wait_idle(1000);
        @(negedge clk);
        check("s1_count", 64'(log_id.size()), 64'(2));
        if (log_id.size() == 2) begin
            check("s1_id0", 64'(log_id[0]), 64'(0));
            check("s1_id1", 64'(log_id[1]), 64'(2));
            check("s1_data0", log_data[0], 64'(100));
            check("s1_data1", log_data[1], 64'(100));
        end
        check("s1_en0_cycles", 64'(en_cnt[0]), 64'(100));
        check("s1_en2_cycles", 64'(en_cnt[2]), 64'(100));
        check("s1_done_cnt", 64'(done_cnt), 64'(1));

        // Zero window becomes one cycle.
        clear_logs();
        begin_sweep(4'b1000, 32'd0);
        wait_idle(200);
        @(negedge clk);
        check("s2_en3_cycles", 64'(en_cnt[3]), 64'(1));
        check("s2_count", 64'(log_id.size()), 64'(1));
        if (log_id.size() == 1) begin
            check("s2_id", 64'(log_id[0]), 64'(3));
            check("s2_data", log_data[0], 64'(1));
        end

        // Backpressure: output holds for 20 cycles, next clear waits for ready.
        clear_logs();
        result_ready = 1'b0;
        begin_sweep(4'b0011, 32'd5);
        wait_valid(100);
        repeat (20) begin
            check("s3_hold_valid", 64'(result_valid), 64'(1));
            check("s3_hold_data", result_data, 64'(5));
            check("s3_hold_id", 64'(result_id), 64'(0));
            check("s3_no_clear", 64'(cnt_reset), 64'(0));
            @(negedge clk);
        end
        result_ready = 1'b1;
        @(negedge clk);
        check("s3_clear_after_ready", 64'(cnt_reset), 64'(1));
        check("s3_valid_dropped", 64'(result_valid), 64'(0));
        wait_idle(500);

        // Ignored starts: empty mask while idle, any start while busy.
        @(negedge clk);
        start = 1'b1; sensor_mask = '0; window_cycles = 32'd7;
        @(negedge clk);
        start = 1'b0;
        check("s4_empty_mask_busy", 64'(busy), 64'(0));
        clear_logs();
        begin_sweep(4'b0001, 32'd30);
        wait_en(0, 50);
        @(negedge clk);
        start = 1'b1; sensor_mask = 4'b1111; window_cycles = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("s4_busy_during_run", 64'(busy), 64'(1));
        check("s4_en_during_run", 64'(sensor_en), 64'(4'b0001));
        wait_idle(500);
        @(negedge clk);
        check("s4_en0_cycles", 64'(en_cnt[0]), 64'(30));
        check("s4_other_en", 64'(en_cnt[1] + en_cnt[2] + en_cnt[3]), 64'(0));
        check("s4_count", 64'(log_id.size()), 64'(1));
        check("s4_done_cnt", 64'(done_cnt), 64'(1));

        // Abort while sensor 1 runs.
        clear_logs();
        begin_sweep(4'b0010, 32'd20);
        wait_en(1, 50);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("s5_busy", 64'(busy), 64'(0));
        check("s5_en", 64'(sensor_en), 64'(0));
        check("s5_cnt_reset", 64'(cnt_reset), 64'(1));
        check("s5_valid", 64'(result_valid), 64'(0));
        repeat (10) @(negedge clk);
        check("s5_no_done", 64'(done_cnt), 64'(0));
        check("s5_no_result", 64'(log_id.size()), 64'(0));

        // Asynchronous reset mid-run, observed before the next clock edge.
        begin_sweep(4'b0100, 32'd50);
        wait_en(2, 50);
        repeat (5) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("s6_en", 64'(sensor_en), 64'(0));
        check("s6_busy", 64'(busy), 64'(0));
        check("s6_valid", 64'(result_valid), 64'(0));
        check("s6_cnt_reset", 64'(cnt_reset), 64'(1));
        check("s6_data", result_data, 64'(0));
        check("s6_id", 64'(result_id), 64'(0));
        check("s6_done", 64'(done), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        // Randomized sweeps with backpressure, spurious starts and rare aborts.
        for (int it = 0; it < 40; it++) begin
            int n;
            for (int i = 0; i < N; i++) step[i] = 1 + int'($urandom_range(4));
            @(negedge clk);
            start = 1'b1;
            sensor_mask = N'($urandom_range(15));
            window_cycles = 32'($urandom_range(12));
            abort = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (!busy) break;
                start         = ($urandom_range(9) == 0);
                sensor_mask   = N'($urandom_range(15));
                window_cycles = 32'($urandom_range(12));
                result_ready  = ($urandom_range(3) != 0);
                abort         = ($urandom_range(49) == 0);
            end while (n < 600);
            start = 1'b0;
            abort = 1'b0;
            check("rand_sweep_end", 64'(busy), 64'(0));
        end
        result_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ro_sensor_scheduler.md
RO_SENSOR_SCHEDULER -- requirements
Module: ro_sensor_scheduler

Interface
REQ-001 Parameter NUM_SENSORS, default 4: number of ring-oscillator sensors/counters sequenced.
REQ-002 Parameter CLEAR_CYCLES, default 4: cycles counter reset is held before each window.
REQ-003 Parameter SETTLE_CYCLES, default 8: cycles after oscillator disable before count capture.
REQ-004 clk  input  1: single system clock; all state changes on rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 start  input  1: one-cycle request to begin a measurement sweep.
REQ-007 abort  input  1: terminate any sweep in progress.
REQ-008 sensor_mask  input  NUM_SENSORS: sensors to measure this sweep, sampled at accept.
REQ-009 window_cycles  input  32: measurement window length in clk cycles, sampled at accept.
REQ-010 cnt_val  input  64*NUM_SENSORS: counter outputs, sensor i at bits [64*i+63:64*i].
REQ-011 sensor_en  output  NUM_SENSORS: oscillator enable, one-hot or zero.
REQ-012 cnt_reset  output  1: reset to all sensor counters.
REQ-013 result_valid  output  1: result_data/result_id valid.
REQ-014 result_ready  input  1: consumer accepts result.
REQ-015 result_data  output  64: captured count.
REQ-016 result_id  output  8: index of sensor that produced result_data.
REQ-017 busy  output  1: high in every state except IDLE.
REQ-018 done  output  1: one-cycle pulse when a sweep completes normally.

Function
REQ-019 FSM states SHALL be IDLE, CLEAR, RUN, SETTLE, CAPTURE, OUTPUT.
REQ-020 IDLE: start=1 with sensor_mask!=0 SHALL latch mask and window, select lowest set mask bit, go CLEAR; start with mask=0 or while busy SHALL be ignored.
REQ-021 window_cycles=0 SHALL be latched as 1.
REQ-022 cnt_reset SHALL be 1 in IDLE and CLEAR, 0 elsewhere.
REQ-023 CLEAR SHALL last exactly CLEAR_CYCLES cycles, then RUN.
REQ-024 RUN: sensor_en[sel]=1, all other bits 0, for exactly the latched window cycles, then SETTLE.
REQ-025 sensor_en SHALL be all-zero in every state except RUN.
REQ-026 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then CAPTURE (cnt_val is stable because the oscillator is stopped; no synchronizer on cnt_val).
REQ-027 CAPTURE SHALL last one cycle, register cnt_val slice sel into result_data and sel into result_id, then OUTPUT.
REQ-028 OUTPUT: result_valid=1; result_data/result_id SHALL hold stable until result_valid&&result_ready.
REQ-029 On handshake: if a higher set bit remains in the latched mask, select the next higher one and go CLEAR; else go IDLE and pulse done for one cycle.
REQ-030 result_valid SHALL be asserted only in OUTPUT, and handshake occurs no earlier than the first OUTPUT cycle.
REQ-031 abort=1 in any non-IDLE state SHALL return to IDLE next cycle with sensor_en=0, result_valid=0, no done pulse; abort has priority over all transitions.
REQ-032 Window and phase counters SHALL be 32 bits; no wrap within one phase.

Reset
REQ-033 On reset: state IDLE, sensor_en=0, cnt_reset=1, result_valid=0, result_data=0, result_id=0, busy=0, done=0, latched mask/window=0.
REQ-034 Reset asserted mid-sweep SHALL take effect immediately, dropping sensor_en and result_valid without waiting for clk.

Verification
REQ-035 mask=4'b0101, window=100, ready tied 1, counters modeled at 1 tick/clk -> results id 0 then id 2, each data=100, sensor_en high exactly 100 cycles each, done once.
REQ-036 mask=4'b1000, window=0 -> sensor_en[3] high exactly 1 cycle, result_id=3, data=1.
REQ-037 ready held 0 for 20 cycles in OUTPUT -> result_valid and data stable 20 cycles, no CLEAR entered until ready=1.
REQ-038 start with mask=0, and start pulse during RUN -> both ignored, busy/state unaffected.
REQ-039 abort during RUN of sensor 1 -> next cycle IDLE, sensor_en=0, cnt_reset=1, no result, no done.
REQ-040 reset asserted mid-RUN between clk edges -> sensor_en and busy drop asynchronously, all outputs at REQ-033 values.
